// File: rtl/prf_pkg.sv
// ---------------------------------------------------------------------------
// prf_pkg
// Shared constants for the physical register file read and write side.
// Holds the default register index and data widths, the hard-wired zero
// register index, and the number of PRF read ports. Also defines the tag
// used to record where a granted read's response data will come from.
// ---------------------------------------------------------------------------
package prf_pkg;

  localparam int REG_ADDR_WIDTH = 6;
  localparam int REG_DATA_WIDTH = 64;
  localparam int NUM_RD_PORTS   = 2;

  localparam logic [REG_ADDR_WIDTH-1:0] PREG_ZERO = '0;

  // Source of a response: the constant-zero register, or one of the two
  // PRF read ports.
  typedef enum logic [1:0] {
    SRC_ZERO  = 2'd0,
    SRC_PORT0 = 2'd1,
    SRC_PORT1 = 2'd2
  } resp_src_e;

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Purely combinational round-robin picker that selects up to two requesters
// per cycle. The scan starts at ptr_i and walks upward modulo N. The first
// active requester found wins slot 0 and the second wins slot 1.
// Ports:
//   req_i     N-bit request mask
//   ptr_i     scan start index, must be < N
//   grant0_o  one-hot grant of the first winner (zero if none)
//   grant1_o  one-hot grant of the second winner (zero if none)
//   valid0_o  a first winner exists
//   valid1_o  a second winner exists
// ---------------------------------------------------------------------------
module rr_pick2 #(
  parameter int N  = 7,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant0_o,
  output logic [N-1:0]  grant1_o,
  output logic          valid0_o,
  output logic          valid1_o
);

  localparam logic [PW:0] NUM = (PW+1)'(N);

  logic [PW:0]   slot;
  logic [PW-1:0] idx;

  // Walk all N slots starting at the pointer. The one-bit-wider sum keeps
  // the modulo wrap exact for any N, including non-powers of two.
  always_comb begin
    grant0_o = '0;
    grant1_o = '0;
    valid0_o = 1'b0;
    valid1_o = 1'b0;
    slot     = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      slot = {1'b0, ptr_i} + (PW+1)'(k);
      if (slot >= NUM) begin
        slot = slot - NUM;
      end
      idx = slot[PW-1:0];
      if (req_i[idx]) begin
        if (!valid0_o) begin
          grant0_o[idx] = 1'b1;
          valid0_o      = 1'b1;
        end else if (!valid1_o) begin
          grant1_o[idx] = 1'b1;
          valid1_o      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prf_read_arbiter.sv
// ---------------------------------------------------------------------------
// prf_read_arbiter
// Maps NUM_REQ physical register file read requests onto the PRF's two
// synchronous read ports. Up to two non-zero reads are granted per cycle in
// round-robin order. Reads of preg 0 are always granted, use no port, and
// return zero. Responses arrive exactly one cycle after the grant. A write
// to the granted register in the grant cycle is forwarded, because the PRF
// itself returns the value from before the write.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush                         kill the responses of this cycle's grants
//   rd_req_valid/addr/ready       per-requester request handshake
//   rd_resp_valid/data            per-requester response, one cycle later
//   prf_rd{0,1}_en/addr/data      PRF read ports; data is valid one cycle
//                                 after the enable
//   wr_first_*/wr_second_*        PRF write ports, observed for forwarding
// ---------------------------------------------------------------------------
module prf_read_arbiter #(
  parameter int NUM_REQ        = 7,
  parameter int REG_ADDR_WIDTH = prf_pkg::REG_ADDR_WIDTH,
  parameter int REG_DATA_WIDTH = prf_pkg::REG_DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [NUM_REQ-1:0]                  rd_req_valid,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]   rd_req_addr,
  output logic [NUM_REQ-1:0]                  rd_req_ready,
  output logic [NUM_REQ-1:0]                  rd_resp_valid,
  output logic [NUM_REQ*REG_DATA_WIDTH-1:0]   rd_resp_data,
  output logic                                prf_rd0_en,
  output logic [REG_ADDR_WIDTH-1:0]           prf_rd0_addr,
  input  logic [REG_DATA_WIDTH-1:0]           prf_rd0_data,
  output logic                                prf_rd1_en,
  output logic [REG_ADDR_WIDTH-1:0]           prf_rd1_addr,
  input  logic [REG_DATA_WIDTH-1:0]           prf_rd1_data,
  input  logic                                wr_first_valid,
  input  logic [REG_ADDR_WIDTH-1:0]           wr_first_address,
  input  logic [REG_DATA_WIDTH-1:0]           wr_first_data,
  input  logic                                wr_second_valid,
  input  logic [REG_ADDR_WIDTH-1:0]           wr_second_address,
  input  logic [REG_DATA_WIDTH-1:0]           wr_second_data
);

  import prf_pkg::*;

  localparam int AW = REG_ADDR_WIDTH;
  localparam int DW = REG_DATA_WIDTH;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(PREG_ZERO);

  logic [AW-1:0]           reqAddr [NUM_REQ];
  logic [NUM_REQ-1:0]      reqZero;
  logic [NUM_REQ-1:0]      reqNonZero;
  logic [NUM_REQ-1:0]      grant0;
  logic [NUM_REQ-1:0]      grant1;
  logic                    pick0Valid;
  logic                    pick1Valid;
  logic [NUM_REQ-1:0]      acceptMask;

  logic [NUM_REQ-1:0]      portGrant [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] portEn;
  logic [AW-1:0]           portAddr [NUM_RD_PORTS];
  logic [PW-1:0]           winIdx [NUM_RD_PORTS];
  logic [DW-1:0]           prfData [NUM_RD_PORTS];
  logic [DW-1:0]           portData [NUM_RD_PORTS];
  logic [PW-1:0]           lastWin;

  logic [PW-1:0]           rrPtr_q, rrPtr_d;
  logic [NUM_REQ-1:0]      respValid_q, respValid_d;
  resp_src_e               respSrc_q [NUM_REQ];
  resp_src_e               respSrc_d [NUM_REQ];
  logic [NUM_RD_PORTS-1:0] fwdHit_q, fwdHit_d;
  logic [DW-1:0]           fwdData_q [NUM_RD_PORTS];
  logic [DW-1:0]           fwdData_d [NUM_RD_PORTS];

  for (genvar g = 0; g < NUM_REQ; g++) begin : gReqAddr
    assign reqAddr[g] = rd_req_addr[g*AW +: AW];
  end

  // Split valid requests into zero-register reads, which bypass the
  // arbiter entirely, and real reads that compete for the two ports.
  always_comb begin
    reqZero    = '0;
    reqNonZero = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqZero[i]    = rd_req_valid[i] && (reqAddr[i] == ZERO_ADDR);
      reqNonZero[i] = rd_req_valid[i] && (reqAddr[i] != ZERO_ADDR);
    end
  end

  rr_pick2 #(
    .N  (NUM_REQ),
    .PW (PW)
  ) uPick (
    .req_i    (reqNonZero),
    .ptr_i    (rrPtr_q),
    .grant0_o (grant0),
    .grant1_o (grant1),
    .valid0_o (pick0Valid),
    .valid1_o (pick1Valid)
  );

  assign acceptMask   = reqZero | grant0 | grant1;
  assign portGrant[0] = grant0;
  assign portGrant[1] = grant1;
  assign portEn       = {pick1Valid, pick0Valid};
  assign prfData[0]   = prf_rd0_data;
  assign prfData[1]   = prf_rd1_data;

  // Turn each one-hot grant into the winner's address and index. An unused
  // port keeps address 0.
  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      portAddr[p] = '0;
      winIdx[p]   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (portGrant[p][i]) begin
          portAddr[p] = reqAddr[i];
          winIdx[p]   = PW'(i);
        end
      end
    end
  end

  // The pointer moves just past the last non-zero winner. It stays put when
  // only zero reads (or nothing) were granted. Flush does not affect it.
  always_comb begin
    rrPtr_d = rrPtr_q;
    lastWin = portEn[1] ? winIdx[1] : winIdx[0];
    if (portEn != '0) begin
      rrPtr_d = (lastWin == PW'(NUM_REQ - 1)) ? '0 : lastWin + PW'(1);
    end
  end

  // The PRF returns pre-write data, so a write landing on a granted address
  // in the grant cycle has to be captured here. The second write port is
  // checked first so that it takes priority over the first.
  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      fwdHit_d[p]  = 1'b0;
      fwdData_d[p] = '0;
      if (portEn[p] && (portAddr[p] != ZERO_ADDR)) begin
        if (wr_second_valid && (wr_second_address == portAddr[p])) begin
          fwdHit_d[p]  = 1'b1;
          fwdData_d[p] = wr_second_data;
        end else if (wr_first_valid && (wr_first_address == portAddr[p])) begin
          fwdHit_d[p]  = 1'b1;
          fwdData_d[p] = wr_first_data;
        end
      end
    end
  end

  // Each accepted request produces one response next cycle unless it is
  // flushed now. Record which port the data will come from.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      respValid_d[i] = acceptMask[i] && !flush;
      respSrc_d[i]   = grant0[i] ? SRC_PORT0 : (grant1[i] ? SRC_PORT1 : SRC_ZERO);
    end
  end

  // Pipeline state. Reset clears everything, which drops any in-flight
  // responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q     <= '0;
      respValid_q <= '0;
      fwdHit_q    <= '0;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        fwdData_q[p] <= '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        respSrc_q[i] <= SRC_ZERO;
      end
    end else begin
      rrPtr_q     <= rrPtr_d;
      respValid_q <= respValid_d;
      fwdHit_q    <= fwdHit_d;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        fwdData_q[p] <= fwdData_d[p];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        respSrc_q[i] <= respSrc_d[i];
      end
    end
  end

  // Request-side outputs are forced quiet while reset is held.
  assign rd_req_ready = rst ? '0 : acceptMask;
  assign prf_rd0_en   = ~rst & portEn[0];
  assign prf_rd1_en   = ~rst & portEn[1];
  assign prf_rd0_addr = rst ? '0 : portAddr[0];
  assign prf_rd1_addr = rst ? '0 : portAddr[1];

  // Response data combines the registered source tag with PRF data that
  // arrives this cycle. Forwarded write data overrides the PRF. Lanes
  // without a valid response read as zero.
  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      portData[p] = fwdHit_q[p] ? fwdData_q[p] : prfData[p];
    end
    rd_resp_valid = rst ? '0 : respValid_q;
    rd_resp_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (respValid_q[i] && !rst) begin
        case (respSrc_q[i])
          SRC_PORT0: rd_resp_data[i*DW +: DW] = portData[0];
          SRC_PORT1: rd_resp_data[i*DW +: DW] = portData[1];
          default:   rd_resp_data[i*DW +: DW] = '0;
        endcase
      end
    end
  end

endmodule
